m_uc_mem_responder: RTL and testbench

//  Memory-side responder for the VirtIO micro controller's data port. Decodes its
//  per-cycle request (req/addr/ctrl/wdata/mmuwe) for the off-chip region (addr[31:28]!=0).

---
 rtl/m_uc_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_m_uc_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_uc_mem_responder.sv
// Off-chip memory responder for the micro controller data port: stalls the core,
// runs one DRAM/MMU transaction, and returns a lane-aligned, extended load result.
// Optional watchdog enabled by defining UC_RESP_TIMEOUT_EN.
module m_uc_mem_responder #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [1:0]  w_mic_req,
  input  logic [31:0] w_mic_addr,
  input  logic [31:0] w_mic_wdata,
  input  logic [2:0]  w_mic_ctrl,
  input  logic        w_mic_mmuwe,
  output logic        w_stall,
  output logic [31:0] w_data,
  output logic        w_mem_valid,
  output logic        w_mem_we,
  output logic [31:0] w_mem_addr,
  output logic [3:0]  w_mem_be,
  output logic [31:0] w_mem_wdata,
  input  logic        w_mem_ready,
  input  logic        w_mem_rvalid,
  input  logic [31:0] w_mem_rdata,
  output logic        w_err
);

  localparam logic [1:0] ACCESS_WRITE = 2'd1;
  localparam logic [1:0] ACCESS_READ  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_e;

  function automatic logic [3:0] lane_be(input logic [1:0] lane, input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [31:0] wd, input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] lane,
                                           input logic [2:0] ctrl);
    logic [31:0] t;
    t = rdata >> {lane, 3'b000};
    case (ctrl)
      3'b000:  return {{24{t[7]}}, t[7:0]};
      3'b100:  return {24'h0, t[7:0]};
      3'b001:  return {{16{t[15]}}, t[15:0]};
      3'b101:  return {16'h0, t[15:0]};
      default: return t;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        hit_r, hit_w;

  assign hit_r = (w_mic_req == ACCESS_READ) && (w_mic_addr[31:28] != 4'h0);
  assign hit_w = (w_mic_req == ACCESS_WRITE) && w_mic_mmuwe;

`ifdef UC_RESP_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    lane_d     = lane_q;
    ctrl_d     = ctrl_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    w_stall    = 1'b0;
`ifdef UC_RESP_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (hit_r || hit_w) begin
          w_stall    = 1'b1;
          state_d    = S_REQ;
          mem_addr_d = {w_mic_addr[31:2], 2'b00};
          lane_d     = w_mic_addr[1:0];
          ctrl_d     = w_mic_ctrl;
          we_d       = hit_w;
          be_d       = lane_be(w_mic_addr[1:0], w_mic_ctrl);
          wdata_d    = lane_wdata(w_mic_wdata, w_mic_ctrl);
`ifdef UC_RESP_TIMEOUT_EN
          cnt_d      = 16'h0;
`endif
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (w_mem_ready) state_d = we_q ? S_DONE : S_WAIT_R;
      end
      S_WAIT_R: begin
        w_stall = 1'b1;
        // rvalid is only meaningful once the read has been accepted.
        if (w_mem_rvalid) begin
          data_d  = fmt_load(w_mem_rdata, lane_q, ctrl_q);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UC_RESP_TIMEOUT_EN
    if (state_q == S_REQ || state_q == S_WAIT_R) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_q == 16'(TIMEOUT_CYC - 1) && state_d != S_DONE) begin
        state_d = S_DONE;
        err_d   = 1'b1;
        if (!we_q) data_d = ERR_DATA;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q    <= S_IDLE;
      mem_addr_q <= 32'h0;
      lane_q     <= 2'b00;
      ctrl_q     <= 3'b000;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      data_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      lane_q     <= lane_d;
      ctrl_q     <= ctrl_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
    end
  end

`ifdef UC_RESP_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      cnt_q <= 16'h0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign w_err = err_q;
`else
  assign w_err = 1'b0;
`endif

  assign w_data      = data_q;
  assign w_mem_valid = (state_q == S_REQ);
  assign w_mem_we    = we_q;
  assign w_mem_addr  = mem_addr_q;
  assign w_mem_be    = be_q;
  assign w_mem_wdata = wdata_q;

endmodule

// File: tb/tb_m_uc_mem_responder.sv
// Self-checking bench for m_uc_mem_responder: directed cases plus randomized accesses
// against a byte-lane reference model; the watchdog case runs when UC_RESP_TIMEOUT_EN is defined.
module tb_m_uc_mem_responder;

`ifdef UC_RESP_TIMEOUT_EN
  localparam int unsigned TO_CYC = 8;
`else
  localparam int unsigned TO_CYC = 1024;
`endif

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic [1:0]  mic_req = 2'd3;
  logic [31:0] mic_addr = 32'h0;
  logic [31:0] mic_wdata = 32'h0;
  logic [2:0]  mic_ctrl = 3'd0;
  logic        mic_mmuwe = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        w_stall, w_mem_valid, w_mem_we, w_err;
  logic [31:0] w_data, w_mem_addr, w_mem_wdata;
  logic [3:0]  w_mem_be;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_data = 32'h0;

  m_uc_mem_responder #(.TIMEOUT_CYC(TO_CYC), .ERR_DATA(32'hDEADBEEF)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .w_mic_req(mic_req), .w_mic_addr(mic_addr), .w_mic_wdata(mic_wdata),
    .w_mic_ctrl(mic_ctrl), .w_mic_mmuwe(mic_mmuwe),
    .w_stall(w_stall), .w_data(w_data),
    .w_mem_valid(w_mem_valid), .w_mem_we(w_mem_we), .w_mem_addr(w_mem_addr),
    .w_mem_be(w_mem_be), .w_mem_wdata(w_mem_wdata),
    .w_mem_ready(mem_ready), .w_mem_rvalid(mem_rvalid), .w_mem_rdata(mem_rdata),
    .w_err(w_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] ctrl);
    return (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [2:0] ctrl);
    int sz  = acc_size(ctrl);
    int off = (sz == 4) ? 0 : (int'(addr % 4) / sz) * sz;
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] ctrl);
    logic [31:0] r;
    int sz = acc_size(ctrl);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] ctrl);
    logic [31:0] t = rdata >> (8 * (addr % 4));
    int sz = (ctrl == 3'b000 || ctrl == 3'b100) ? 1 : (ctrl == 3'b001 || ctrl == 3'b101) ? 2 : 4;
    longint v;
    if (sz == 4) return t;
    v = longint'(t) & ((64'd1 << (8 * sz)) - 1);
    if (!ctrl[2] && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    return 32'(v);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "/stall"},  32'(w_stall),     32'h0);
    check({tag, "/data"},   w_data,           32'h0);
    check({tag, "/valid"},  32'(w_mem_valid), 32'h0);
    check({tag, "/we"},     32'(w_mem_we),    32'h0);
    check({tag, "/addr"},   w_mem_addr,       32'h0);
    check({tag, "/be"},     32'(w_mem_be),    32'h0);
    check({tag, "/wdata"},  w_mem_wdata,      32'h0);
    check({tag, "/err"},    32'(w_err),       32'h0);
  endtask

  // One controller access; the bench plays the downstream memory with the given delays.
  task automatic do_access(input string tag, input logic [1:0] req, input logic [31:0] addr,
                           input logic [2:0] ctrl, input logic [31:0] wd, input logic mmuwe,
                           input int rdy_dly, input int rv_dly, input logic [31:0] rdata);
    bit hit_r = (req == 2'd2) && (addr[31:28] != 4'h0);
    bit hit_w = (req == 2'd1) && mmuwe;
    int exp_stall = hit_r ? rdy_dly + rv_dly + 3 : (hit_w ? rdy_dly + 2 : 0);
    int stall_cnt = 0, txn = 0, wait_cnt = 0, valid_cyc = 0;
    bit waiting_r = 0, done = 0, unstable = 0;
    logic [31:0] cap_addr = 'x, cap_wd = 'x;
    logic [3:0]  cap_be = 'x;
    logic        cap_we = 1'bx;

    @(negedge CLK);
    mic_req = req; mic_addr = addr; mic_ctrl = ctrl; mic_wdata = wd; mic_mmuwe = mmuwe;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      if (!w_stall) done = 1;
      else begin
        stall_cnt++;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (w_mem_valid) begin
          if (valid_cyc == 0) begin
            cap_addr = w_mem_addr; cap_wd = w_mem_wdata; cap_be = w_mem_be; cap_we = w_mem_we;
          end else if ({w_mem_addr, w_mem_wdata, w_mem_be, w_mem_we} !== {cap_addr, cap_wd, cap_be, cap_we})
            unstable = 1;
          valid_cyc++;
          if (wait_cnt == rdy_dly) begin
            mem_ready = 1'b1; txn++; wait_cnt = 0; waiting_r = !cap_we;
          end else wait_cnt++;
        end else if (waiting_r) begin
          if (wait_cnt == rv_dly) begin
            mem_rvalid = 1'b1; mem_rdata = rdata; waiting_r = 0;
          end else wait_cnt++;
        end
        @(negedge CLK);
      end
    end
    if (!done) check({tag, "/stall_bound"}, 32'(done), 32'h1);

    if (hit_r) exp_data = model_load(rdata, addr, ctrl);
    check({tag, "/stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    check({tag, "/txn_count"},    32'(txn),       32'((hit_r || hit_w) ? 1 : 0));
    check({tag, "/valid_end"},    32'(w_mem_valid), 32'h0);
    check({tag, "/data"},         w_data,         exp_data);
    if (hit_r || hit_w) begin
      check({tag, "/mem_addr"}, cap_addr,         {addr[31:2], 2'b00});
      check({tag, "/mem_we"},   32'(cap_we),      32'(hit_w));
      check({tag, "/mem_be"},   32'(cap_be),      32'(model_be(addr, ctrl)));
      check({tag, "/held"},     32'(unstable),    32'h0);
      if (hit_w) check({tag, "/mem_wdata"}, cap_wd, model_wdata(wd, ctrl));
    end else begin
      for (int i = 0; i < 3; i++) begin
        @(negedge CLK); #1;
        check({tag, "/idle_stall"}, 32'(w_stall),     32'h0);
        check({tag, "/idle_valid"}, 32'(w_mem_valid), 32'h0);
      end
    end
    mic_req = 2'd3; mic_mmuwe = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge CLK); #1;
    check({tag, "/data_held"}, w_data, exp_data);
  endtask

  initial begin : stim
    logic [2:0] rd_ctrls [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] a;
    logic [1:0]  rq;
    logic [2:0]  c;

    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset_held");
    RST_X = 1'b1;

    do_access("lw",  2'd2, 32'h8000_0004, 3'b010, 32'h0, 1'b0, 0, 1, 32'h1122_3344);
    do_access("lb",  2'd2, 32'h8000_0003, 3'b000, 32'h0, 1'b0, 1, 0, 32'h80FF_FFFF);
    do_access("lbu", 2'd2, 32'h8000_0003, 3'b100, 32'h0, 1'b0, 0, 2, 32'h80FF_FFFF);
    do_access("lh",  2'd2, 32'h9000_0002, 3'b001, 32'h0, 1'b0, 2, 1, 32'h8001_1234);
    do_access("lhu", 2'd2, 32'h9000_0002, 3'b101, 32'h0, 1'b0, 0, 0, 32'h8001_1234);
    do_access("sb",  2'd1, 32'h8000_0001, 3'b000, 32'h0000_00AB, 1'b1, 3, 0, 32'h0);
    do_access("sh",  2'd1, 32'hA000_0006, 3'b001, 32'h5555_BEEF, 1'b1, 1, 0, 32'h0);
    do_access("sw",  2'd1, 32'hA000_0008, 3'b010, 32'hCAFE_F00D, 1'b1, 0, 0, 32'h0);
    do_access("local_rd", 2'd2, 32'h0000_0100, 3'b010, 32'h0, 1'b0, 0, 0, 32'h1234_5678);
    do_access("code",     2'd0, 32'h8000_0100, 3'b010, 32'h0, 1'b0, 0, 0, 32'h1234_5678);
    do_access("wr_no_we", 2'd1, 32'h8000_0100, 3'b010, 32'h1, 1'b0, 0, 0, 32'h0);

    // Reset while the read is waiting for data; the late rvalid must be dropped.
    @(negedge CLK);
    mic_req = 2'd2; mic_addr = 32'h8000_0010; mic_ctrl = 3'b010;
    @(negedge CLK);
    mem_ready = 1'b1;
    @(negedge CLK);
    mem_ready = 1'b0; mic_req = 2'd3;
    #1;
    check("rst_mid/stall_before", 32'(w_stall), 32'h1);
    RST_X = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge CLK);
    RST_X = 1'b1;
    @(negedge CLK);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge CLK);
    mem_rvalid = 1'b0;
    #1;
    exp_data = 32'h0;
    check("rst_mid/late_rvalid_data",  w_data,           32'h0);
    check("rst_mid/late_rvalid_stall", 32'(w_stall),     32'h0);
    check("rst_mid/late_rvalid_valid", 32'(w_mem_valid), 32'h0);

    for (int n = 0; n < 24; n++) begin
      a  = $urandom;
      if ($urandom_range(0, 4) == 0) a[31:28] = 4'h0;
      rq = 2'($urandom_range(0, 3));
      c  = (rq == 2'd1) ? 3'($urandom_range(0, 2)) : rd_ctrls[$urandom_range(0, 4)];
      do_access($sformatf("rnd%0d", n), rq, a, c, $urandom, 1'($urandom_range(0, 3) != 0),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

`ifdef UC_RESP_TIMEOUT_EN
    begin : timeout_case
      int  stall_cnt = 0;
      bit  done = 0;
      @(negedge CLK);
      mic_req = 2'd2; mic_addr = 32'h8000_0020; mic_ctrl = 3'b010;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
        #1;
        if (!w_stall) done = 1;
        else begin
          stall_cnt++;
          mem_ready = w_mem_valid; mem_rvalid = 1'b0;
          @(negedge CLK);
        end
      end
      check("timeout/released",    32'(done),        32'h1);
      check("timeout/stall_cycles", 32'(stall_cnt),  32'(TO_CYC + 1));
      check("timeout/data",        w_data,           32'hDEADBEEF);
      check("timeout/err",         32'(w_err),       32'h1);
      check("timeout/valid",       32'(w_mem_valid), 32'h0);
      mic_req = 2'd3; mem_ready = 1'b0;
      exp_data = 32'hDEADBEEF;
      do_access("after_to", 2'd2, 32'h8000_0024, 3'b010, 32'h0, 1'b0, 0, 0, 32'h0BAD_F00D);
      check("timeout/err_sticky", 32'(w_err), 32'h1);
    end
`else
    check("no_watchdog/err", 32'(w_err), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
